// File: rtl/bcam_pkg.sv
// Shared BCAM definitions: default geometry and match-reader FSM state type.
// Also used by the BCAM array and the search controller.
package bcam_pkg;

  localparam int BCAM_ENTRIES = 16;
  localparam int BCAM_ADDR_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } rdr_state_t;

endpackage

// File: rtl/bcam_prio_enc.sv
// Combinational lowest-set-bit encoder over a BCAM match vector.
module bcam_prio_enc #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 4
) (
  input  logic [ENTRIES-1:0] vec,
  output logic [ADDR_W-1:0]  idx,
  output logic               any
);

  // Scan from the top down so the lowest set bit wins the last assignment.
  always_comb begin
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/bcam_match_reader.sv
// Drains a captured BCAM match vector as a stream of ascending entry addresses.
// One search is held at a time; new vectors are refused while emitting.
module bcam_match_reader
  import bcam_pkg::*;
#(
  parameter int ENTRIES = BCAM_ENTRIES,
  parameter int ADDR_W  = BCAM_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               match_valid,
  output logic               match_ready,
  input  logic [ENTRIES-1:0] match_vec,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic [ADDR_W-1:0]  addr,
  output logic               last,
  output logic               multi_hit,
  output logic [ADDR_W:0]    hit_count,
  output logic               no_hit
);

  rdr_state_t          state_q, state_d;
  logic [ENTRIES-1:0]  pend_q;
  logic [ADDR_W:0]     hit_count_q;
  logic                multi_hit_q;
  logic                no_hit_q;

  logic [ADDR_W-1:0]   enc_idx;
  logic                enc_any;
  logic [ENTRIES-1:0]  pend_rest;
  logic                single;
  logic [ADDR_W:0]     cap_cnt;
  logic                capture;
  logic                accept;

  bcam_prio_enc #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W)
  ) u_enc (
    .vec (pend_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // pend with its lowest hit removed; empty means the current beat is the last one.
  assign pend_rest = pend_q & ~(ENTRIES'(1) << enc_idx);
  assign single    = enc_any && (pend_rest == '0);

  always_comb begin
    cap_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      cap_cnt = cap_cnt + (ADDR_W+1)'(match_vec[i]);
    end
  end

  assign capture = match_valid && match_ready;
  assign accept  = addr_valid && addr_ready;

  always_comb begin
    state_d     = state_q;
    match_ready = 1'b0;
    addr_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        match_ready = 1'b1;
        if (match_valid && (match_vec != '0)) state_d = EMIT;
      end
      EMIT: begin
        addr_valid = 1'b1;
        if (addr_ready && single) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      hit_count_q <= '0;
      multi_hit_q <= 1'b0;
      no_hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      no_hit_q <= capture && (match_vec == '0);
      if (capture) begin
        pend_q      <= match_vec;
        hit_count_q <= cap_cnt;
        multi_hit_q <= cap_cnt > (ADDR_W+1)'(1);
      end else if (accept) begin
        pend_q <= pend_rest;
      end
    end
  end

  // pend is zero in IDLE, so addr/last fall to 0 there without extra gating.
  assign addr      = enc_idx;
  assign last      = single;
  assign hit_count = hit_count_q;
  assign multi_hit = multi_hit_q;
  assign no_hit    = no_hit_q;

endmodule
